// File: rtl/dcache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// with a single-outstanding Wishbone master port and a walk-the-index FENCE.I flush.
module dcache #(
  parameter int unsigned LINES         = 256,
  parameter logic [3:0]  CACHED_REGION = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_be_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  input  logic        flush_req_i,
  output logic        flush_done_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 30 - IdxW;

  typedef enum logic [1:0] {StIdle, StBus, StFlush} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [IdxW-1:0]   flush_cnt_q, flush_cnt_d;
  logic              wb_cyc_q, wb_cyc_d;
  logic              wb_we_q, wb_we_d;
  logic [31:0]       wb_adr_q, wb_adr_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic [3:0]        wb_sel_q, wb_sel_d;

  logic [TagW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IdxW-1:0]   cpu_idx, bus_idx;
  logic [TagW-1:0]   cpu_tag, bus_tag;
  logic              cpu_cached, bus_cached, cpu_hit, bus_hit;
  logic              fill, store_upd;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign cpu_idx    = cpu_addr_i[2 +: IdxW];
  assign cpu_tag    = cpu_addr_i[31 -: TagW];
  assign cpu_cached = (cpu_addr_i[31:28] == CACHED_REGION);
  assign cpu_hit    = cpu_cached && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // The registered bus address identifies the line when the access retires.
  assign bus_idx    = wb_adr_q[2 +: IdxW];
  assign bus_tag    = wb_adr_q[31 -: TagW];
  assign bus_cached = (wb_adr_q[31:28] == CACHED_REGION);
  assign bus_hit    = bus_cached && valid_q[bus_idx] && (tag_q[bus_idx] == bus_tag);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_cnt_d  = flush_cnt_q;
    wb_cyc_d     = wb_cyc_q;
    wb_we_d      = wb_we_q;
    wb_adr_d     = wb_adr_q;
    wb_dat_d     = wb_dat_q;
    wb_sel_d     = wb_sel_q;
    cpu_ready_o  = 1'b0;
    cpu_rdata_o  = 32'h0;
    flush_done_o = 1'b0;
    fill         = 1'b0;
    store_upd    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_req_i) begin
          state_d = StFlush;
        end else if (cpu_valid_i) begin
          if (!cpu_we_i && cpu_hit) begin
            cpu_ready_o = 1'b1;
            cpu_rdata_o = data_q[cpu_idx];
          end else begin
            state_d  = StBus;
            wb_cyc_d = 1'b1;
            wb_we_d  = cpu_we_i;
            wb_adr_d = {cpu_addr_i[31:2], 2'b00};
            wb_dat_d = cpu_wdata_i;
            wb_sel_d = cpu_we_i ? cpu_be_i : 4'hF;
          end
        end
      end

      StBus: begin
        if (wb_ack_i) begin
          cpu_ready_o = 1'b1;
          cpu_rdata_o = wb_dat_i;
          wb_cyc_d    = 1'b0;
          state_d     = StIdle;
          if (bus_cached) begin
            if (!wb_we_q) begin
              fill             = 1'b1;
              valid_d[bus_idx] = 1'b1;
            end else if (bus_hit) begin
              store_upd = 1'b1;
            end
          end
        end
      end

      StFlush: begin
        valid_d[flush_cnt_q] = 1'b0;
        if (flush_cnt_q == IdxW'(LINES - 1)) begin
          flush_done_o = 1'b1;
          flush_cnt_d  = '0;
          state_d      = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q + IdxW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      flush_cnt_q <= '0;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= 32'h0;
      wb_dat_q    <= 32'h0;
      wb_sel_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      flush_cnt_q <= flush_cnt_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_sel_q    <= wb_sel_d;
    end
  end

  // Arrays carry no reset; reset forces StIdle at once, so fill/store_upd fall before any edge.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[bus_idx] <= wb_dat_i;
      tag_q[bus_idx]  <= bus_tag;
    end else if (store_upd) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_q[b]) data_q[bus_idx][8*b +: 8] <= wb_dat_q[8*b +: 8];
      end
    end
  end

  assign wb_cyc_o = wb_cyc_q;
  assign wb_stb_o = wb_cyc_q;
  assign wb_we_o  = wb_we_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_sel_o = wb_sel_q;

endmodule
